// File: rtl/color_pkg.sv
// Shared constants and types for the colour compositor: status encodings,
// the 8-bit-per-channel RGB record, palette offsets and reset colours.
package color_pkg;

    localparam logic [3:0] ST_WAITING = 4'b1000;
    localparam logic [3:0] ST_PLAYING = 4'b0100;
    localparam logic [3:0] ST_WIN     = 4'b0010;
    localparam logic [3:0] ST_LOSE    = 4'b0001;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Screen entries sit directly after the layer colours.
    localparam int PAL_WAITING = 0;
    localparam int PAL_WIN     = 1;
    localparam int PAL_LOSE    = 2;
    localparam int PAL_SKY     = 3;

    localparam rgb_t DEF_BLACK   = rgb_t'(24'h000000);
    localparam rgb_t DEF_LAYER1  = rgb_t'(24'hFFFF00);
    localparam rgb_t DEF_LAYER2  = rgb_t'(24'h404040);
    localparam rgb_t DEF_LAYER3  = rgb_t'(24'h101010);
    localparam rgb_t DEF_WAITING = rgb_t'(24'h404040);
    localparam rgb_t DEF_WIN     = rgb_t'(24'h800000);
    localparam rgb_t DEF_LOSE    = rgb_t'(24'h008000);
    localparam rgb_t DEF_SKY     = rgb_t'(24'h4F4F7F);

    function automatic rgb_t default_entry(input int idx, input int num_layers);
        rgb_t c;
        c = DEF_BLACK;
        if (idx < num_layers) begin
            case (idx)
                1:       c = DEF_LAYER1;
                2:       c = DEF_LAYER2;
                3:       c = DEF_LAYER3;
                default: c = DEF_BLACK;
            endcase
        end else begin
            case (idx - num_layers)
                PAL_WAITING: c = DEF_WAITING;
                PAL_WIN:     c = DEF_WIN;
                PAL_LOSE:    c = DEF_LOSE;
                PAL_SKY:     c = DEF_SKY;
                default:     c = DEF_BLACK;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/fade_ctrl.sv
// Frame-boundary status latch with optional fade-out/fade-in level sequencing.
// The fade FSM is only built when COLOR_FADE_EN is defined.
module fade_ctrl
    import color_pkg::*;
#(
    parameter int FADE_FRAMES = 16,
    localparam int LVL_W = $clog2(FADE_FRAMES) + 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             frame_start,
    input  logic [3:0]       status,
    output logic [3:0]       cur_status,
    output logic [LVL_W-1:0] lvl
);

    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FADE_FRAMES);

    logic [3:0] cur_reg;
    assign cur_status = cur_reg;

`ifdef COLOR_FADE_EN
    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_FADE_OUT = 2'd1;
    localparam logic [1:0] S_FADE_IN  = 2'd2;

    logic [1:0]       state_reg, state_next;
    logic [LVL_W-1:0] lvl_reg, lvl_next;
    logic [3:0]       cur_next;
    logic [3:0]       target_reg, target_next;
    logic             step_out;

    assign lvl = lvl_reg;

    always_comb begin
        state_next  = state_reg;
        lvl_next    = lvl_reg;
        cur_next    = cur_reg;
        target_next = target_reg;
        step_out    = 1'b0;
        if (frame_start) begin
            case (state_reg)
                S_IDLE:     step_out = (status != cur_reg);
                S_FADE_OUT: step_out = 1'b1;
                S_FADE_IN: begin
                    if (status != cur_reg) begin
                        step_out = 1'b1;
                    end else begin
                        lvl_next = lvl_reg + 1'b1;
                        if (lvl_reg == LVL_FULL - 1'b1)
                            state_next = S_IDLE;
                    end
                end
                default:    state_next = S_IDLE;
            endcase
        end
        // One fade-out step; reaching black swaps the screen and turns around.
        if (step_out) begin
            target_next = status;
            if (lvl_reg <= LVL_W'(1)) begin
                lvl_next   = '0;
                cur_next   = status;
                state_next = S_FADE_IN;
            end else begin
                lvl_next   = lvl_reg - 1'b1;
                state_next = S_FADE_OUT;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_reg  <= S_IDLE;
            lvl_reg    <= LVL_FULL;
            cur_reg    <= ST_WAITING;
            target_reg <= ST_WAITING;
        end else begin
            state_reg  <= state_next;
            lvl_reg    <= lvl_next;
            cur_reg    <= cur_next;
            target_reg <= target_next;
        end
    end
`else
    assign lvl = LVL_FULL;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            cur_reg <= ST_WAITING;
        else if (frame_start)
            cur_reg <= status;
    end
`endif

endmodule

// File: rtl/color_compositor.sv
// Two-stage per-pixel compositor: layer priority, palette lookup, sky gradient
// and fade scaling. Define COLOR_FADE_EN to build the fade FSM and multiplier.
module color_compositor
    import color_pkg::*;
#(
    parameter int NUM_LAYERS  = 4,
    parameter int COLOR_W     = 8,
    parameter int FADE_FRAMES = 16,
    localparam int AW = $clog2(NUM_LAYERS + 4)
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   pix_valid,
    input  logic [9:0]             DrawX,
    input  logic [9:0]             DrawY,
    input  logic [NUM_LAYERS-1:0]  layer_hit,
    input  logic [3:0]             status,
    input  logic                   frame_start,
    input  logic                   pal_we,
    input  logic [AW-1:0]          pal_addr,
    input  logic [3*COLOR_W-1:0]   pal_data,
    output logic                   pal_ready,
    output logic [COLOR_W-1:0]     VGA_R,
    output logic [COLOR_W-1:0]     VGA_G,
    output logic [COLOR_W-1:0]     VGA_B,
    output logic                   out_valid
);

    localparam int PAL_N   = NUM_LAYERS + 4;
    localparam int IDX_W   = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam int CW3     = 3 * COLOR_W;
    localparam int LVL_W   = $clog2(FADE_FRAMES) + 1;
    localparam int DW      = COLOR_W + 8;
    localparam int SKY_IDX = NUM_LAYERS + PAL_SKY;

    // Reset colours are 8-bit; left-align them into COLOR_W-bit channels.
    function automatic logic [COLOR_W-1:0] widen(input logic [7:0] ch);
        logic [COLOR_W+7:0] t;
        t = {ch, {COLOR_W{1'b0}}};
        return t[COLOR_W+7:8];
    endfunction

    function automatic logic [CW3-1:0] pal_default(input int idx);
        rgb_t c;
        c = default_entry(idx, NUM_LAYERS);
        return {widen(c.r), widen(c.g), widen(c.b)};
    endfunction

    logic [3:0]       cur_status;
    logic [LVL_W-1:0] lvl;

    fade_ctrl #(.FADE_FRAMES(FADE_FRAMES)) u_fade (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_start (frame_start),
        .status      (status),
        .cur_status  (cur_status),
        .lvl         (lvl)
    );

    // Palette with a single pending write slot committed at frame_start.
    logic [CW3-1:0] pal_reg [PAL_N];
    logic           pend_valid_reg;
    logic [AW-1:0]  pend_addr_reg;
    logic [CW3-1:0] pend_data_reg;

    assign pal_ready = !pend_valid_reg;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pend_valid_reg <= 1'b0;
            pend_addr_reg  <= '0;
            pend_data_reg  <= '0;
            for (int i = 0; i < PAL_N; i++)
                pal_reg[i] <= pal_default(i);
        end else if (pal_we && !pend_valid_reg) begin
            pend_valid_reg <= 1'b1;
            pend_addr_reg  <= pal_addr;
            pend_data_reg  <= pal_data;
        end else if (frame_start && pend_valid_reg) begin
            pend_valid_reg <= 1'b0;
            for (int i = 0; i < PAL_N; i++)
                if (int'(pend_addr_reg) == i)
                    pal_reg[i] <= pend_data_reg;
        end
    end

    // Stage 1: lowest set layer wins.
    logic [IDX_W-1:0] hit_idx;
    logic             s1_valid_reg;
    logic             s1_hit_reg;
    logic [IDX_W-1:0] s1_idx_reg;
    logic [6:0]       s1_x_reg;

    always_comb begin
        hit_idx = '0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--)
            if (layer_hit[i])
                hit_idx = IDX_W'(i);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            s1_valid_reg <= 1'b0;
            s1_hit_reg   <= 1'b0;
            s1_idx_reg   <= '0;
            s1_x_reg     <= '0;
        end else begin
            s1_valid_reg <= pix_valid;
            s1_hit_reg   <= |layer_hit;
            s1_idx_reg   <= hit_idx;
            s1_x_reg     <= DrawX[9:3];
        end
    end

    // Stage 2: colour selection.
    logic [CW3-1:0]     sel;
    logic [DW-1:0]      sky_b_ext;
    logic [DW-1:0]      x_ext;
    logic [COLOR_W-1:0] grad_b;

    always_comb begin
        sky_b_ext = DW'(pal_reg[SKY_IDX][COLOR_W-1:0]);
        x_ext     = DW'(s1_x_reg);
        grad_b    = (sky_b_ext < x_ext) ? '0 : COLOR_W'(sky_b_ext - x_ext);
        sel       = '0;
        case (cur_status)
            ST_WAITING: sel = pal_reg[NUM_LAYERS + PAL_WAITING];
            ST_WIN:     sel = pal_reg[NUM_LAYERS + PAL_WIN];
            ST_LOSE:    sel = pal_reg[NUM_LAYERS + PAL_LOSE];
            ST_PLAYING: begin
                if (s1_hit_reg)
                    sel = pal_reg[AW'(s1_idx_reg)];
                else
                    sel = {pal_reg[SKY_IDX][CW3-1 -: COLOR_W],
                           pal_reg[SKY_IDX][CW3-1 -: COLOR_W], grad_b};
            end
            default:    sel = '0;
        endcase
    end

    logic [COLOR_W-1:0] scaled [3];

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_ch
            logic [COLOR_W-1:0] c;
            assign c = sel[gi*COLOR_W +: COLOR_W];
`ifdef COLOR_FADE_EN
            localparam int LOG2F = $clog2(FADE_FRAMES);
            localparam int PW    = COLOR_W + LOG2F + 1;
            logic [PW-1:0] prod;
            assign prod       = PW'(c) * PW'(lvl);
            assign scaled[gi] = COLOR_W'(prod >> LOG2F);
`else
            assign scaled[gi] = c;
`endif
        end
    endgenerate

`ifndef COLOR_FADE_EN
    logic unused_lvl;
    assign unused_lvl = ^lvl;
`endif
    logic unused_coords;
    assign unused_coords = ^{DrawY, DrawX[2:0]};

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            VGA_R     <= '0;
            VGA_G     <= '0;
            VGA_B     <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= s1_valid_reg;
            VGA_R     <= s1_valid_reg ? scaled[2] : '0;
            VGA_G     <= s1_valid_reg ? scaled[1] : '0;
            VGA_B     <= s1_valid_reg ? scaled[0] : '0;
        end
    end

endmodule

// File: tb/tb_color_compositor.sv
// Directed, table-driven bench for color_compositor with default parameters.
// Fade sequences are exercised only when COLOR_FADE_EN is defined.
module tb_color_compositor;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pix_valid = 1'b0;
    logic [9:0]  draw_x = '0;
    logic [9:0]  draw_y = '0;
    logic [3:0]  layer_hit = '0;
    logic [3:0]  status = 4'b1000;
    logic        frame_start = 1'b0;
    logic        pal_we = 1'b0;
    logic [2:0]  pal_addr = '0;
    logic [23:0] pal_data = '0;
    logic        pal_ready;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic        out_valid;

    int checks = 0;
    int errors = 0;

    localparam logic [3:0] WAIT = 4'b1000;
    localparam logic [3:0] PLAY = 4'b0100;
    localparam logic [3:0] WIN  = 4'b0010;
    localparam logic [3:0] LOSE = 4'b0001;

    color_compositor dut (
        .Clk         (clk),
        .Reset       (rst),
        .pix_valid   (pix_valid),
        .DrawX       (draw_x),
        .DrawY       (draw_y),
        .layer_hit   (layer_hit),
        .status      (status),
        .frame_start (frame_start),
        .pal_we      (pal_we),
        .pal_addr    (pal_addr),
        .pal_data    (pal_data),
        .pal_ready   (pal_ready),
        .VGA_R       (vga_r),
        .VGA_G       (vga_g),
        .VGA_B       (vga_b),
        .out_valid   (out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  st;
        logic [3:0]  hit;
        logic [9:0]  x;
        logic [23:0] exp_rgb;
    } vec_t;

    vec_t vecs [14];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic pixel(input string name, input logic [3:0] hit, input logic [9:0] x,
                         input logic [23:0] exp_rgb);
        pix_valid = 1'b1;
        layer_hit = hit;
        draw_x    = x;
        draw_y    = 10'd100;
        tick();
        pix_valid = 1'b0;
        layer_hit = '0;
        tick();
        $display("pix %s status=%b hit=%b x=%0d rgb=%h exp=%h valid=%b",
                 name, status, hit, x, {vga_r, vga_g, vga_b}, exp_rgb, out_valid);
        chk({name, "_rgb"}, {8'h0, vga_r, vga_g, vga_b}, {8'h0, exp_rgb});
        chk({name, "_valid"}, {31'h0, out_valid}, 32'd1);
    endtask

    task automatic frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic go_status(input logic [3:0] s);
        status = s;
`ifdef COLOR_FADE_EN
        repeat (32) frame();
`else
        frame();
`endif
    endtask

    task automatic pal_write(input logic [2:0] a, input logic [23:0] d);
        pal_addr = a;
        pal_data = d;
        pal_we   = 1'b1;
        tick();
        pal_we   = 1'b0;
        $display("wr addr=%0d data=%h ready=%b", a, d, pal_ready);
    endtask

    initial begin
        vecs[0]  = '{PLAY, 4'b0110, 10'd0,   24'hFFFF00};
        vecs[1]  = '{PLAY, 4'b0001, 10'd0,   24'h000000};
        vecs[2]  = '{PLAY, 4'b1000, 10'd0,   24'h101010};
        vecs[3]  = '{PLAY, 4'b0100, 10'd0,   24'h404040};
        vecs[4]  = '{PLAY, 4'b1111, 10'd0,   24'h000000};
        vecs[5]  = '{PLAY, 4'b0000, 10'd639, 24'h4F4F30};
        vecs[6]  = '{PLAY, 4'b0000, 10'd0,   24'h4F4F7F};
        vecs[7]  = '{PLAY, 4'b0000, 10'd8,   24'h4F4F7E};
        vecs[8]  = '{PLAY, 4'b1100, 10'd0,   24'h404040};
        vecs[9]  = '{WIN,  4'b0001, 10'd0,   24'h800000};
        vecs[10] = '{LOSE, 4'b0000, 10'd0,   24'h008000};
        vecs[11] = '{WAIT, 4'b0010, 10'd0,   24'h404040};
        vecs[12] = '{4'b0000, 4'b0001, 10'd0, 24'h000000};
        vecs[13] = '{4'b1100, 4'b0000, 10'd0, 24'h000000};

        rst = 1'b1;
        tick();
        tick();
        chk("reset_rgb", {8'h0, vga_r, vga_g, vga_b}, 32'h0);
        chk("reset_valid", {31'h0, out_valid}, 32'd0);
        chk("reset_ready", {31'h0, pal_ready}, 32'd1);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 14; i++) begin
            if (vecs[i].st != status)
                go_status(vecs[i].st);
            pixel($sformatf("vec%0d", i), vecs[i].hit, vecs[i].x, vecs[i].exp_rgb);
        end

        // Idle cycle: no valid pixel means blank outputs.
        tick();
        chk("idle_rgb", {8'h0, vga_r, vga_g, vga_b}, 32'h0);
        chk("idle_valid", {31'h0, out_valid}, 32'd0);

        // Palette write held until frame_start.
        go_status(PLAY);
        pal_write(3'd0, 24'h00FF00);
        chk("wr_ready_low", {31'h0, pal_ready}, 32'd0);
        pixel("wr_before", 4'b0001, 10'd0, 24'h000000);
        frame();
        chk("wr_ready_high", {31'h0, pal_ready}, 32'd1);
        pixel("wr_after", 4'b0001, 10'd0, 24'h00FF00);

        // Write accepted alongside frame_start waits for the next one.
        pal_addr    = 3'd0;
        pal_data    = 24'h0000FF;
        pal_we      = 1'b1;
        frame_start = 1'b1;
        tick();
        pal_we      = 1'b0;
        frame_start = 1'b0;
        chk("wr_fs_ready_low", {31'h0, pal_ready}, 32'd0);
        pixel("wr_fs_before", 4'b0001, 10'd0, 24'h00FF00);
        frame();
        pixel("wr_fs_after", 4'b0001, 10'd0, 24'h0000FF);

        // Sky gradient saturation with a dark sky base.
        pal_write(3'd7, 24'h4F4F10);
        frame();
        pixel("sat_639", 4'b0000, 10'd639, 24'h4F4F00);
        pixel("sat_128", 4'b0000, 10'd128, 24'h4F4F00);
        pixel("sat_120", 4'b0000, 10'd120, 24'h4F4F01);
        pixel("sat_0",   4'b0000, 10'd0,   24'h4F4F10);

`ifdef COLOR_FADE_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        status = WAIT;
        tick();
        pixel("fade_full", 4'b0000, 10'd0, 24'h404040);
        status = WIN;
        frame();
        pixel("fade_out1", 4'b0000, 10'd0, 24'h3C3C3C);
        repeat (15) frame();
        pixel("fade_black", 4'b0000, 10'd0, 24'h000000);
        repeat (16) frame();
        pixel("fade_win", 4'b0000, 10'd0, 24'h800000);
        status = WAIT;
        repeat (16) frame();
        repeat (5) frame();
        pixel("fade_in5", 4'b0000, 10'd0, 24'h141414);
        status = LOSE;
        frame();
        pixel("fade_rev4", 4'b0000, 10'd0, 24'h101010);
        frame();
        pixel("fade_rev3", 4'b0000, 10'd0, 24'h0C0C0C);
`else
        status = WIN;
        pixel("latch_hold", 4'b0001, 10'd0, 24'h0000FF);
        frame();
        pixel("latch_win", 4'b0001, 10'd0, 24'h800000);
`endif

        // Reset mid-stream with a write pending.
        pal_write(3'd0, 24'hFFFFFF);
        chk("rst_pend_ready", {31'h0, pal_ready}, 32'd0);
        pix_valid = 1'b1;
        draw_x    = 10'd0;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_rgb", {8'h0, vga_r, vga_g, vga_b}, 32'h0);
        chk("rst_async_valid", {31'h0, out_valid}, 32'd0);
        chk("rst_async_ready", {31'h0, pal_ready}, 32'd1);
        pix_valid = 1'b0;
        status    = WAIT;
        tick();
        rst = 1'b0;
        tick();
        pixel("rst_waiting", 4'b0000, 10'd0, 24'h404040);
        frame();
        go_status(PLAY);
        pixel("rst_pal_l0", 4'b0001, 10'd0, 24'h000000);
        pixel("rst_pal_sky", 4'b0000, 10'd0, 24'h4F4F7F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
